// File: rtl/bcd_down_timer_pkg.sv
// Shared types and constants for the cascaded BCD countdown timer.
package bcd_down_timer_pkg;

   localparam int DIGIT_W = 4;

   // Digit moduli from least significant digit upward: 10, 6, 10, 10 gives mm:ss.
   localparam logic [15:0] MMSS_MOD_VEC = 16'hAA6A;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } timer_state_e;

endpackage

// File: rtl/bcd_down_timer_digit.sv
// One down-counting digit with its own modulus; clamps out-of-range load values.
module bcd_digit_down
   import bcd_down_timer_pkg::*;
#(
   parameter int MOD = 10
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               load,
   input  logic [DIGIT_W-1:0] ld_val,
   input  logic               dec_in,
   output logic [DIGIT_W-1:0] digit,
   output logic               borrow_out
);

   localparam logic [DIGIT_W-1:0] MOD_L   = DIGIT_W'(MOD);
   localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(MOD - 1);

   logic [DIGIT_W-1:0] digit_q;
   logic [DIGIT_W-1:0] digit_d;

   always_comb begin
      digit_d = digit_q;
      if (load) begin
         digit_d = (ld_val >= MOD_L) ? MAX_VAL : ld_val;
      end else if (dec_in) begin
         digit_d = (digit_q == '0) ? MAX_VAL : digit_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) digit_q <= '0;
      else     digit_q <= digit_d;
   end

   // A borrow ripples onward only when this digit wraps from zero.
   assign borrow_out = dec_in && (digit_q == '0);
   assign digit      = digit_q;

endmodule

// File: rtl/bcd_down_timer.sv
// N-digit cascaded BCD countdown timer with run/pause/cancel control and expiry pulse.
module bcd_down_timer
   import bcd_down_timer_pkg::*;
#(
   parameter int                     NDIGITS = 4,
   parameter logic [4*NDIGITS-1:0]   MOD_VEC = (4*NDIGITS)'(MMSS_MOD_VEC)
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 loadn,
   input  logic [4*NDIGITS-1:0] data,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 tick,
   output logic [4*NDIGITS-1:0] count,
   output logic                 zero,
   output logic                 running,
   output logic                 done
);

   localparam logic [4*NDIGITS-1:0] COUNT_ONE = (4*NDIGITS)'(1);

   timer_state_e state_q, state_d;
   logic         running_q, done_q;
   logic         load_en, cancel, dec_en;
   logic [NDIGITS:0] borrow;

   assign zero = (count == '0);

   always_comb begin
      state_d = state_q;
      load_en = 1'b0;
      cancel  = 1'b0;
      dec_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!loadn)              load_en = 1'b1;
            else if (start && !zero) state_d = RUN;
         end
         RUN: begin
            if (stop) begin
               state_d = PAUSED;
            end else if (zero) begin
               state_d = IDLE;
            end else if (tick) begin
               dec_en = 1'b1;
               // Reaching zero on this tick expires on the same edge.
               if (count == COUNT_ONE) state_d = EXPIRED;
            end
         end
         PAUSED: begin
            if (stop) begin
               load_en = 1'b1;
               cancel  = 1'b1;
               state_d = IDLE;
            end else if (!loadn) begin
               load_en = 1'b1;
            end else if (start && !zero) begin
               state_d = RUN;
            end
         end
         EXPIRED: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= IDLE;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= (state_d == RUN);
         done_q    <= (state_d == EXPIRED);
      end
   end

   assign running   = running_q;
   assign done      = done_q;
   assign borrow[0] = dec_en;

   // Cancel reuses the load path with an all-zero value.
   for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
      logic [DIGIT_W-1:0] ld_val;
      assign ld_val = cancel ? '0 : data[4*i +: 4];

      bcd_digit_down #(
         .MOD(int'(MOD_VEC[4*i +: 4]))
      ) u_digit (
         .clk       (clk),
         .clr       (clr),
         .load      (load_en),
         .ld_val    (ld_val),
         .dec_in    (borrow[i]),
         .digit     (count[4*i +: 4]),
         .borrow_out(borrow[i+1])
      );
   end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed self-checking bench for bcd_down_timer in its default mm:ss configuration.
module tb_bcd_down_timer;

   logic        clk = 1'b0;
   logic        clr;
   logic        loadn;
   logic [15:0] data;
   logic        start;
   logic        stop;
   logic        tick;
   logic [15:0] count;
   logic        zero;
   logic        running;
   logic        done;

   int total = 0;
   int bad   = 0;
   int done_count = 0;

   bcd_down_timer dut (
      .clk    (clk),
      .clr    (clr),
      .loadn  (loadn),
      .data   (data),
      .start  (start),
      .stop   (stop),
      .tick   (tick),
      .count  (count),
      .zero   (zero),
      .running(running),
      .done   (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (done === 1'b1) done_count++;
   end

   function automatic logic [15:0] mmss(input int s);
      int m, sec;
      m   = s / 60;
      sec = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
   endfunction

   task automatic do_load(input logic [15:0] v);
      loadn = 1'b0; data = v;
      @(negedge clk);
      loadn = 1'b1;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic do_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   endtask

   task automatic test_reset();
      clr = 1'b1; loadn = 1'b1; data = '0; start = 0; stop = 0; tick = 0;
      repeat (2) @(negedge clk);
      total++; if (count !== 16'h0000) begin bad++; $display("[TB] FAIL reset_count got=%h want=0000", count); end
      total++; if (zero !== 1'b1) begin bad++; $display("[TB] FAIL reset_zero got=%b want=1", zero); end
      total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL reset_running got=%b want=0", running); end
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
      clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_countdown();
      int errs = 0;
      int run_errs = 0;
      do_load(16'h0130);
      do_start();
      total++; if (running !== 1'b1) begin bad++; $display("[TB] FAIL cd_running_start got=%b want=1", running); end
      done_count = 0;
      for (int k = 1; k <= 90; k++) begin
         do_ticks(1);
         if (count !== mmss(90 - k)) begin
            errs++;
            if (errs < 4) $display("[TB] FAIL cd_step tick=%0d got=%h want=%h", k, count, mmss(90 - k));
         end
         if (k < 90 && (running !== 1'b1 || done !== 1'b0)) run_errs++;
      end
      total++; if (errs != 0) begin bad++; $display("[TB] FAIL cd_sequence wrong_steps=%0d want=0", errs); end
      total++; if (run_errs != 0) begin bad++; $display("[TB] FAIL cd_flags_midrun wrong=%0d want=0", run_errs); end
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL cd_done_pulse got=%b want=1", done); end
      total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL cd_running_drop got=%b want=0", running); end
      total++; if (zero !== 1'b1) begin bad++; $display("[TB] FAIL cd_zero got=%b want=1", zero); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL cd_done_one_cycle got=%b want=0", done); end
      repeat (2) @(negedge clk);
      total++; if (done_count != 1) begin bad++; $display("[TB] FAIL cd_done_count got=%0d want=1", done_count); end
      do_start();
      total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL idle_zero_start got=%b want=0", running); end
   endtask

   task automatic test_borrow();
      do_load(16'h1000);
      do_start();
      do_ticks(1);
      total++; if (count !== 16'h0959) begin bad++; $display("[TB] FAIL borrow_1000 got=%h want=0959", count); end
      do_load(16'h4444);
      total++; if (count !== 16'h0959) begin bad++; $display("[TB] FAIL run_ignores_load got=%h want=0959", count); end
      do_stop();
      do_load(16'h0100);
      do_start();
      do_ticks(1);
      total++; if (count !== 16'h0059) begin bad++; $display("[TB] FAIL borrow_0100 got=%h want=0059", count); end
      do_stop();
      do_stop();
      total++; if (count !== 16'h0000 || running !== 1'b0) begin bad++; $display("[TB] FAIL borrow_cancel got=%h/%b want=0000/0", count, running); end
   endtask

   task automatic test_clamp();
      do_load(16'h0097);
      total++; if (count !== 16'h0057) begin bad++; $display("[TB] FAIL clamp_0097 got=%h want=0057", count); end
      do_load(16'hBBBB);
      total++; if (count !== 16'h9959) begin bad++; $display("[TB] FAIL clamp_BBBB got=%h want=9959", count); end
      stop = 1'b1; tick = 1'b1;
      @(negedge clk);
      stop = 1'b0; tick = 1'b0;
      total++; if (count !== 16'h9959) begin bad++; $display("[TB] FAIL idle_ignores_stop got=%h want=9959", count); end
   endtask

   task automatic test_pause_cancel();
      done_count = 0;
      do_load(16'h0010);
      do_start();
      do_ticks(3);
      total++; if (count !== 16'h0007) begin bad++; $display("[TB] FAIL pc_three_ticks got=%h want=0007", count); end
      do_stop();
      total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL pc_paused_running got=%b want=0", running); end
      do_ticks(5);
      total++; if (count !== 16'h0007) begin bad++; $display("[TB] FAIL pc_paused_hold got=%h want=0007", count); end
      do_start();
      total++; if (running !== 1'b1) begin bad++; $display("[TB] FAIL pc_resume got=%b want=1", running); end
      do_ticks(2);
      total++; if (count !== 16'h0005) begin bad++; $display("[TB] FAIL pc_resume_ticks got=%h want=0005", count); end
      do_stop();
      do_stop();
      repeat (2) @(negedge clk);
      total++; if (count !== 16'h0000 || zero !== 1'b1) begin bad++; $display("[TB] FAIL pc_cancel got=%h/%b want=0000/1", count, zero); end
      total++; if (done_count != 0) begin bad++; $display("[TB] FAIL pc_no_done got=%0d want=0", done_count); end
   endtask

   task automatic test_priority();
      do_load(16'h0020);
      do_start();
      stop = 1'b1; tick = 1'b1;
      @(negedge clk);
      stop = 1'b0; tick = 1'b0;
      total++; if (count !== 16'h0020 || running !== 1'b0) begin bad++; $display("[TB] FAIL prio_stop_tick got=%h/%b want=0020/0", count, running); end
      loadn = 1'b0; data = 16'h0033; start = 1'b1;
      @(negedge clk);
      loadn = 1'b1; start = 1'b0;
      total++; if (count !== 16'h0033 || running !== 1'b0) begin bad++; $display("[TB] FAIL prio_load_start got=%h/%b want=0033/0", count, running); end
      loadn = 1'b0; data = 16'h0044; stop = 1'b1; start = 1'b1;
      @(negedge clk);
      loadn = 1'b1; stop = 1'b0; start = 1'b0;
      total++; if (count !== 16'h0000 || running !== 1'b0) begin bad++; $display("[TB] FAIL prio_stop_cancel got=%h/%b want=0000/0", count, running); end
   endtask

   task automatic test_reset_midrun();
      done_count = 0;
      do_load(16'h0045);
      do_start();
      do_ticks(10);
      total++; if (count !== 16'h0035) begin bad++; $display("[TB] FAIL rm_ten_ticks got=%h want=0035", count); end
      #2 clr = 1'b1;
      #1;
      total++; if (count !== 16'h0000 || running !== 1'b0) begin bad++; $display("[TB] FAIL rm_async got=%h/%b want=0000/0", count, running); end
      @(negedge clk);
      clr = 1'b0;
      do_ticks(3);
      total++; if (count !== 16'h0000 || done_count != 0) begin bad++; $display("[TB] FAIL rm_after got=%h done=%0d want=0000 done=0", count, done_count); end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_borrow();
      test_clamp();
      test_pause_cancel();
      test_priority();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
N-digit cascaded BCD down-counter with a run-control FSM. It is the parametrised successor of the single-digit countdown stages, and each digit has its own modulus so one instance covers an mm:ss cook timer. It sits between the keypad/load path and the display/magnetron-control logic. It counts down on an external 1 Hz tick and flags expiry.

Parameters:
NDIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
MOD_VEC, 16'hAA6A, packed 4-bit modulus per digit, digit i at [4i+3:4i], legal 2..10. The default gives mm:ss (10,6,10,10 from LSD).

Ports:
clk  in  1  system clock, all state on rising edge.
clr  in  1  asynchronous active-high reset.
loadn  in  1  synchronous active-low parallel load.
data  in  4*NDIGITS  BCD load value.
start  in  1  request to begin or resume counting (level sampled each cycle).
stop  in  1  pause request; cancel request when already paused.
tick  in  1  single-cycle count enable (1 Hz strobe).
count  out  4*NDIGITS  current BCD value, registered.
zero  out  1  combinational, count == 0.
running  out  1  registered, state == RUN.
done  out  1  registered, one-cycle expiry pulse.

Behaviour:
- Reset (clr high, async): count=0, state=IDLE, running=0, done=0; zero therefore 1. Reset overrides everything, including mid-RUN.
- States: IDLE, RUN, PAUSED, EXPIRED.
- IDLE: loadn=0 loads data. start=1 with nonzero count goes to RUN. start with count==0 stays in IDLE. stop is ignored.
- RUN: tick=1 decrements by one. stop=1 goes to PAUSED, and stop wins over a same-cycle tick (no decrement). A decrement that yields all-zero goes to EXPIRED on the same edge. loadn is ignored.
- PAUSED: count holds; tick is ignored. loadn=0 loads data. start=1 with nonzero count goes to RUN. stop=1 clears count to 0 and goes to IDLE (cancel). If start and stop are both high, stop wins.
- EXPIRED: lasts exactly one cycle. done=1 during that cycle. Next state is IDLE unconditionally; inputs are ignored.
- Priority within a cycle: clr > stop > loadn > start > tick.
- Load clamping: any loaded digit >= its modulus is stored as modulus-1. Example: 9 into a mod-6 digit stores 5.
- Decrement: digit 0 always borrows in. Digit i decrements if it borrows in and is nonzero. It wraps to mod_i-1 and borrows out if it borrows in and is 0. The all-zero state is never decremented; the FSM leaves RUN first.
- Latency: count updates on the edge sampling tick. running and done follow the state register with no extra delay.

Decomposition:
- Shared package: state enum (IDLE, RUN, PAUSED, EXPIRED), DIGIT_W=4, default MOD_VEC constant for mm:ss.
- One sub-module, bcd_digit_down. It takes parameter MOD, inputs load/ld_val/dec_in, and outputs digit/borrow_out, with clamping inside. The top module instantiates it NDIGITS times in a generate loop and holds the FSM.

Test Plan:
- Load 16'h0130, start, 90 ticks: count steps 0130→0129…→0100→0059…→0000. done=1 for exactly one cycle after tick 90; running drops the same cycle; then IDLE.
- Borrow chain: load 16'h1000, start, 1 tick → 0959. Load 16'h0100, 1 tick → 0059.
- Clamp: load 16'h0097 in IDLE → count 16'h0057. Load 16'hBBBB → 16'h9959.
- Pause/cancel: load 0010, start, 3 ticks → 0007. stop → PAUSED, 5 ticks → still 0007. start, 2 ticks → 0005. stop, stop → count 0000, IDLE, done never asserts.
- Edge priority: in RUN, assert stop and tick in the same cycle → PAUSED, no decrement. In IDLE with count 0, start → stays IDLE, running=0.
- Reset mid-run: load 0045, start, 10 ticks, pulse clr asynchronously between edges → count 0000, running 0 immediately. No done pulse follows.
